// File: rtl/pipe_scoreboard_pkg.sv
// pipe_scoreboard_pkg: shared entry layout, encodings and writing predicate for the scoreboard
package pipe_scoreboard_pkg;
  typedef struct packed {
    logic       valid;
    logic       wen;
    logic       is_load;
    logic [4:0] rd;
  } sb_entry_t;
  localparam int ENTRY_W = $bits(sb_entry_t);
  localparam logic [2:0] FWD_RF = 3'd0;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic logic writing(input sb_entry_t e);
    return e.valid && e.wen && e.rd != REG_ZERO;
  endfunction
endpackage

// File: rtl/sb_src_match.sv
// sb_src_match: youngest-producer search for one source operand
//   entries     in  DEPTH*ENTRY_W  tracked stages, stage k at bits [k*ENTRY_W +: ENTRY_W]
//   rs          in  5              source register
//   used        in  1              operand is actually read
//   sel         out 3              0 = register file, k+1 = stage k result
//   load_hazard out 1              selected producer is a load not yet forwardable
module sb_src_match
  import pipe_scoreboard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic [DEPTH*ENTRY_W-1:0] entries,
  input  logic [4:0]               rs,
  input  logic                     used,
  output logic [2:0]               sel,
  output logic                     load_hazard
);
  sb_entry_t e;
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel = FWD_RF;
    load_hazard = 1'b0;
    e = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      e = entries[k*ENTRY_W +: ENTRY_W];
      if (used && rs != REG_ZERO && writing(e) && e.rd == rs) begin
        sel = 3'(k + 1);
        load_hazard = e.is_load && k < LOAD_STAGE;
      end
    end
  end
endmodule

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: in-flight destination tracking with forwarding select and load-use stall
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid/id_rd/id_wen/id_is_load  ID instruction destination info
//   id_rs[NUM_SRC*5], id_uses[NUM_SRC] ID source registers and read enables
//   flush                     kill the ID instruction (dominates stall)
//   stall                     hold PC and IF/ID, bubble into stage 0
//   fwd_sel[NUM_SRC*3]        per-operand source select
//   sb_busy                   some tracked stage holds a writing entry
//   SCOREBOARD_STATS_EN adds saturating stall_cycles and flush_count outputs
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rd,
  input  logic                 id_wen,
  input  logic                 id_is_load,
  input  logic [NUM_SRC*5-1:0] id_rs,
  input  logic [NUM_SRC-1:0]   id_uses,
  input  logic                 flush,
  output logic                 stall,
  output logic [NUM_SRC*3-1:0] fwd_sel,
  output logic                 sb_busy
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          flush_count
`endif
);
  sb_entry_t [DEPTH-1:0] entry;
  logic [NUM_SRC-1:0] hazard;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) entry <= '0;
    else entry <= {entry[DEPTH-2:0], (!stall && !flush) ? sb_entry_t'{id_valid, id_wen, id_is_load, id_rd} : sb_entry_t'('0)};
  end
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    sb_src_match #(.DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE)) u_match (
      .entries    (entry),
      .rs         (id_rs[5*s +: 5]),
      .used       (id_uses[s]),
      .sel        (fwd_sel[3*s +: 3]),
      .load_hazard(hazard[s])
    );
  end
  assign stall = id_valid && !flush && |hazard;
  always_comb begin
    sb_busy = 1'b0;
    for (int k = 0; k < DEPTH; k++) sb_busy = sb_busy | writing(entry[k]);
  end
`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      stall_cycles <= (stall && stall_cycles != '1) ? stall_cycles + 32'd1 : stall_cycles;
      flush_count <= (flush && id_valid && flush_count != '1) ? flush_count + 32'd1 : flush_count;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb_pipe_scoreboard: directed self-checking bench for pipe_scoreboard at default parameters
module tb_pipe_scoreboard;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid = 1'b0, id_wen = 1'b0, id_is_load = 1'b0, flush = 1'b0;
  logic [4:0] id_rd = '0;
  logic [9:0] id_rs = '0;
  logic [1:0] id_uses = '0;
  logic stall, sb_busy;
  logic [5:0] fwd_sel;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  pipe_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_rs(id_rs), .id_uses(id_uses), .flush(flush),
    .stall(stall), .fwd_sel(fwd_sel), .sb_busy(sb_busy)
`ifdef SCOREBOARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic id(input logic v, input logic w, input logic ld, input logic [4:0] rd,
                    input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] u, input logic fl);
    id_valid = v; id_wen = w; id_is_load = ld; id_rd = rd;
    id_rs = {rs1, rs0}; id_uses = u; flush = fl;
    #1;
  endtask
  initial begin
    id(1, 1, 0, 5, 5, 5, 2'b11, 0);
    step;
    check("rst_stall", 32'(stall), 0);
    check("rst_fwd", 32'(fwd_sel), 0);
    check("rst_busy", 32'(sb_busy), 0);
    step;
    id(0, 0, 0, 0, 0, 0, 2'b00, 0);
    rst = 1'b0;
    step;
    // Test 1: addi x5 ; add x6,x5,x5
    id(1, 1, 0, 5, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 6, 5, 5, 2'b11, 0);
    check("t1_fwd", 32'(fwd_sel), 32'd9);
    check("t1_stall", 32'(stall), 0);
    check("t1_busy", 32'(sb_busy), 1);
    step;
    // Test 2: lw x7 ; use x7 -> two stall cycles then stage 2 forward
    id(1, 1, 1, 7, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 8, 0, 7, 2'b01, 0);
    check("t2_stall_c0", 32'(stall), 1);
    step;
    check("t2_stall_c1", 32'(stall), 1);
    step;
    check("t2_stall_rel", 32'(stall), 0);
    check("t2_fwd", 32'(fwd_sel), 32'd3);
    step;
    // Test 3: x5 at stages 0 and 2, x9 at stage 1
    id(1, 1, 0, 5, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 9, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 5, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 10, 9, 5, 2'b11, 0);
    check("t3_fwd", 32'(fwd_sel), 32'd17);
    check("t3_stall", 32'(stall), 0);
    step;
    // Test 4: flushed lw x7 that would itself stall on lw x3
    id(1, 1, 1, 3, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 1, 7, 0, 3, 2'b01, 1);
    check("t4_flush_stall", 32'(stall), 0);
    step;
    id(1, 1, 0, 11, 3, 7, 2'b11, 0);
    check("t4_fwd_nox7", 32'(fwd_sel), 32'd16);
    check("t4_stall_x3", 32'(stall), 1);
    step;
    check("t4_fwd_rel", 32'(fwd_sel), 32'd24);
    check("t4_stall_rel", 32'(stall), 0);
    step;
    // Test 5: x0 producer, and unused operands on a fresh load
    id(1, 1, 0, 0, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 12, 0, 0, 2'b11, 0);
    check("t5_x0_fwd", 32'(fwd_sel), 0);
    check("t5_x0_stall", 32'(stall), 0);
    step;
    id(1, 1, 1, 13, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 14, 13, 13, 2'b00, 0);
    check("t5_unused_fwd", 32'(fwd_sel), 0);
    check("t5_unused_stall", 32'(stall), 0);
    step;
    // Test 6: reset asserted mid-stall
    id(1, 1, 1, 7, 0, 0, 2'b00, 0);
    step;
    id(1, 1, 0, 15, 0, 7, 2'b01, 0);
    check("t6_pre_stall", 32'(stall), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_stall", 32'(stall), 0);
    check("t6_rst_busy", 32'(sb_busy), 0);
    check("t6_rst_fwd", 32'(fwd_sel), 0);
`ifdef SCOREBOARD_STATS_EN
    check("t6_rst_stallcnt", stall_cycles, 0);
`endif
    step;
    rst = 1'b0;
    #1;
    check("t6_post_stall", 32'(stall), 0);
    check("t6_post_fwd", 32'(fwd_sel), 0);
    step;
    check("t6_post_busy", 32'(sb_busy), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_scoreboard.md
PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2, meaning the number of source operands checked per instruction (1..3).
REQ-002 SHALL have parameter DEPTH, default 3, meaning the number of tracked in-flight stages after ID (stage 0 = EX … DEPTH-1 = WB); legal range 2..6.
REQ-003 SHALL have parameter LOAD_STAGE, default 2, meaning the lowest stage index at which load data can be forwarded; legal range 1..DEPTH-1.
REQ-004 SHALL be clocked on one clock and reset asynchronously and active-high (Already decided).
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 id_valid  in  1  ID holds a real instruction.
REQ-008 id_rd  in  5  ID destination register.
REQ-009 id_wen  in  1  ID instruction writes id_rd.
REQ-010 id_is_load  in  1  ID instruction is a load (Reg_WBSel = dmem).
REQ-011 id_rs  in  NUM_SRC*5  ID source registers; operand s in bits [5s+4:5s].
REQ-012 id_uses  in  NUM_SRC  bit s set when operand s is read.
REQ-013 flush  in  1  kill the ID instruction (mispredict/jump redirect).
REQ-014 stall  out  1  hold PC and IF/ID, insert bubble into stage 0.
REQ-015 fwd_sel  out  NUM_SRC*3  per-operand source: 0 = register file, k+1 = stage k result.
REQ-016 sb_busy  out  1  at least one tracked stage holds a valid writing entry.

Function
REQ-017 SHALL keep DEPTH registered entries {valid, wen, is_load, rd[4:0]}.
REQ-018 Every cycle: entry[k] <= entry[k-1] for k = 1..DEPTH-1; entries below stage 0 are never held.
REQ-019 entry[0] SHALL load {id_valid, id_wen, id_is_load, id_rd} when !stall && !flush; else entry[0] SHALL become invalid (bubble).
REQ-020 An entry SHALL be treated as writing only when valid && wen && rd != 0.
REQ-021 For operand s with id_uses[s] && id_rs[s] != 0: fwd_sel[s] = k+1 for the lowest k whose writing entry has rd == id_rs[s]; otherwise 0 (youngest producer wins).
REQ-022 stall SHALL be 1 (combinational, same cycle) when id_valid && !flush and any operand's selected producer at stage k is_load with k < LOAD_STAGE.
REQ-023 While stall = 1, fwd_sel SHALL still reflect the current entries; the bench samples it only when stall = 0.
REQ-024 flush SHALL dominate stall: flush = 1 forces stall = 0 and a bubble into entry[0].
REQ-025 A load-use stall SHALL last exactly LOAD_STAGE - k cycles, then release automatically as the producer advances.
REQ-026 sb_busy SHALL be the OR of the writing condition over all entries.
REQ-027 rd = 0 producers and unused operands SHALL never cause forwarding or stall.

Reset
REQ-028 rst = 1 SHALL clear all entries to invalid immediately, with stall = 0, fwd_sel = 0, and sb_busy = 0 while asserted.
REQ-029 Reset mid-stall SHALL drop the stall in the same cycle; the first post-reset ID instruction SHALL see an empty scoreboard.

Configuration
REQ-030 Macro SCOREBOARD_STATS_EN defined: SHALL add outputs stall_cycles[31:0] and flush_count[31:0], saturating at 32'hFFFFFFFF and cleared by rst.
REQ-031 stall_cycles SHALL increment on each cycle with stall = 1, and flush_count on each cycle with flush = 1 && id_valid.
REQ-032 Macro undefined: neither port nor counter logic SHALL exist.
REQ-033 With the macro undefined, all other behaviour SHALL be identical.

Structure
REQ-034 The shared package SHALL hold the entry struct/width constant, the FWD_RF = 0 encoding, and REG_ZERO = 5'd0.
REQ-035 The per-operand match/priority search SHALL be one sub-module, sb_src_match, instantiated NUM_SRC times.

Verification
REQ-036 Test 1: addi x5 followed by add x6,x5,x5 (defaults) -> next cycle fwd_sel = {3'd1,3'd1} and stall = 0.
REQ-037 Test 2: lw x7 then immediate use of x7 -> stall = 1 for exactly 2 cycles, then fwd_sel[0] = 3 (stage 2) with stall = 0.
REQ-038 Test 3: x5 written at stages 0 and 2 simultaneously -> fwd_sel selects 1 (youngest).
REQ-039 Test 4: lw x7 with the consumer in ID and flush = 1 in the same cycle -> stall = 0, entry[0] is a bubble, and the next cycle has no x7 match from the flushed instruction.
REQ-040 Test 5: write to x0 then read of x0 -> fwd_sel = 0 and stall = 0.
REQ-041 Test 6: rst asserted mid-stall -> stall drops the same cycle and sb_busy = 0; with SCOREBOARD_STATS_EN, stall_cycles = 0 after reset.
